sse_sched: RTL and testbench

Round-robin scheduler that shares one SSE engine (the 8-row × 16-byte, 10-cycle start-to-done SSE datapath) among up to `NUM_REQ` requesters, such as luma and chroma mode-decision units. It accepts one operand-pair request at a time. It latches the operands and holds them stable for the whole engine run, then pulses the engine start. It waits for the engine done, or times out, and returns the 32-bit SSE tagged with the requester ID. It sits between the mode-decision requesters and the SSE engine instance.

---
 rtl/sse_sched_pkg.sv | 28 ++
 rtl/sse_sched_rr_arbiter.sv | 46 ++++
 rtl/sse_sched.sv | 195 +++++++++++++++++++
 tb/tb_sse_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sse_sched_pkg.sv
// sse_sched_pkg
//   Shared declarations for the SSE-engine scheduler:
//   - sched_state_e : scheduler FSM states (IDLE, LAUNCH, WAIT, RESP)
//   - id_w()        : width of a requester index for a given requester count
//   - SSE_ENG_LAT   : start-to-done latency of the SSE engine in cycles
package sse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } sched_state_e;

  localparam int SSE_ENG_LAT = 10;

  // clog2 of the requester count, never narrower than one bit.
  function automatic int id_w(input int num_req);
    int w;
    if (num_req <= 2) begin
      w = 1;
    end else begin
      w = $clog2(num_req);
    end
    return w;
  endfunction

endpackage

// File: rtl/sse_sched_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. The winner is the first set
//   bit of req found by scanning upward from ptr, wrapping past the top.
// Ports:
//   req      in  [NUM_REQ]  pending requests
//   ptr      in  [ID_W]     highest-priority index (must be < NUM_REQ)
//   grant    out [NUM_REQ]  one-hot grant, all zero when nothing pends
//   grant_id out [ID_W]     encoded index of the granted requester
module rr_arbiter
  import sse_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W:0]   raw_s;
  logic [ID_W-1:0] idx_s;
  logic            found_s;
  logic            hit_s;

  // Rotating priority scan; the first pending slot from ptr takes the grant.
  always_comb begin
    grant    = {NUM_REQ{1'b0}};
    grant_id = {ID_W{1'b0}};
    found_s  = 1'b0;
    hit_s    = 1'b0;
    raw_s    = {(ID_W+1){1'b0}};
    idx_s    = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr + k fits in ID_W+1 bits, so one conditional subtract wraps it.
      raw_s = {1'b0, ptr} + (ID_W+1)'(k);
      raw_s = (raw_s >= (ID_W+1)'(NUM_REQ)) ? (raw_s - (ID_W+1)'(NUM_REQ)) : raw_s;
      idx_s = raw_s[ID_W-1:0];
      hit_s = !found_s && req[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      grant_id     = hit_s ? idx_s : grant_id;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/sse_sched.sv
// sse_sched
//   Shares one SSE engine among NUM_REQ requesters. One request is accepted
//   at a time in IDLE, its operands are held on eng_a/eng_b, the engine is
//   started with a single-cycle pulse, and the result (or a timeout error)
//   is returned tagged with the requester index.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready combinational)
//   req_a/req_b         per-requester operand blocks, slice i = requester i
//   eng_start           one-cycle engine start pulse (registered)
//   eng_a/eng_b         operands held for the whole engine run (registered)
//   eng_sse/eng_done    engine result and completion pulse
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_sse/rsp_err  response payload (registered)
module sse_sched
  import sse_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 1024,
  parameter  int SSE_W   = 32,
  parameter  int TIMEOUT = 15,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_a,
  output logic [DATA_W-1:0]         eng_b,
  input  logic [SSE_W-1:0]          eng_sse,
  input  logic                      eng_done,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [SSE_W-1:0]          rsp_sse,
  output logic                      rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              eng_start_q, eng_start_d;
  logic [DATA_W-1:0] eng_a_q, eng_a_d;
  logic [DATA_W-1:0] eng_b_q, eng_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [SSE_W-1:0]  rsp_sse_q, rsp_sse_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_id_s;
  logic [ID_W-1:0]    next_ptr_s;
  logic [DATA_W-1:0]  a_sel_s;
  logic [DATA_W-1:0]  b_sel_s;
  logic               accept_s;
  logic [CNT_W-1:0]   tmo_next_s;
  logic               tmo_hit_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  // Grants are offered only from IDLE, and never while reset is held.
  always_comb begin
    if ((state_q == ST_IDLE) && !rst) begin
      req_ready = grant_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  assign accept_s   = |req_ready;
  assign next_ptr_s = (grant_id_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                         : (grant_id_s + ID_W'(1));
  // The counter value after this WAIT cycle; reaching TIMEOUT ends the run.
  assign tmo_next_s = tmo_cnt_q + CNT_W'(1);
  assign tmo_hit_s  = (tmo_next_s == CNT_W'(TIMEOUT));

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    a_sel_s = {DATA_W{1'b0}};
    b_sel_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      a_sel_s = a_sel_s | ({DATA_W{grant_s[i]}} & req_a[i*DATA_W +: DATA_W]);
      b_sel_s = b_sel_s | ({DATA_W{grant_s[i]}} & req_b[i*DATA_W +: DATA_W]);
    end
  end

  // Next-state and next-output logic of the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    eng_start_d = 1'b0;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sse_d   = rsp_sse_q;
    rsp_err_d   = rsp_err_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          eng_a_d     = a_sel_s;
          eng_b_d     = b_sel_s;
          rsp_id_d    = grant_id_s;
          rr_ptr_d    = next_ptr_s;
          eng_start_d = 1'b1;
          state_d     = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        tmo_cnt_d = {CNT_W{1'b0}};
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_next_s;
        // A completion in the same cycle as the timeout still counts as done.
        if (eng_done) begin
          rsp_sse_d   = eng_sse;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (tmo_hit_s) begin
          rsp_sse_d   = {SSE_W{1'b0}};
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= {ID_W{1'b0}};
      eng_start_q <= 1'b0;
      eng_a_q     <= {DATA_W{1'b0}};
      eng_b_q     <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_sse_q   <= {SSE_W{1'b0}};
      rsp_err_q   <= 1'b0;
      tmo_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      eng_start_q <= eng_start_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sse_q   <= rsp_sse_d;
      rsp_err_q   <= rsp_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign eng_start = eng_start_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sse   = rsp_sse_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sse_sched.sv
// tb_sse_sched
//   Directed bench for sse_sched with a behavioural SSE engine model and a
//   response scoreboard (expected entries pushed at accept, popped at the
//   response handshake).
module tb_sse_sched;
  import sse_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 1024;
  localparam int SSE_W   = 32;
  localparam int TIMEOUT = 15;
  localparam int NBYTES  = DATA_W / 8;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sse;
    logic        err;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      eng_start;
  logic [DATA_W-1:0]         eng_a;
  logic [DATA_W-1:0]         eng_b;
  logic [SSE_W-1:0]          eng_sse;
  logic                      eng_done;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [1:0]                rsp_id;
  logic [SSE_W-1:0]          rsp_sse;
  logic                      rsp_err;

  logic [7:0] a_byte [NUM_REQ] = '{8'h10, 8'h20, 8'h05, 8'hF0};
  logic [7:0] b_byte [NUM_REQ] = '{8'h01, 8'h30, 8'h02, 8'h00};

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Engine model controls.
  bit          eng_en     = 1'b1;
  int          eng_lat    = SSE_ENG_LAT;
  int          eng_cnt    = 0;
  logic        model_done = 1'b0;
  logic [31:0] model_sse  = 32'd0;
  logic        stray_done = 1'b0;

  assign eng_done = model_done | stray_done;
  assign eng_sse  = model_sse;

  always #5 clk = ~clk;

  sse_sched #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .SSE_W   (SSE_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .eng_start (eng_start),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_sse   (eng_sse),
    .eng_done  (eng_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sse   (rsp_sse),
    .rsp_err   (rsp_err)
  );

  function automatic logic [31:0] engine_sse(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int s = 0;
    int d;
    for (int k = 0; k < NBYTES; k++) begin
      d = int'(a[8*k +: 8]) - int'(b[8*k +: 8]);
      s = s + d * d;
    end
    return 32'(s);
  endfunction

  function automatic logic [31:0] exp_sse(input int i);
    int d = int'(a_byte[i]) - int'(b_byte[i]);
    return 32'(d * d * NBYTES);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed[31:0]=%0h expected[31:0]=%0h", tag, obs[31:0], exp[31:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant, checks it and its timing, then checks the start pulse.
  task automatic accept(input int exp_id, input logic [3:0] after_mask, input logic exp_err, input int exp_n);
    int         n = 0;
    exp_t       e;
    logic [3:0] oh = 4'b0001 << exp_id;
    while (req_ready === 4'b0000 && n < 50) begin
      step();
      @(negedge clk);
      n++;
    end
    chk("grant", 64'(req_ready), 64'(oh));
    if (exp_n >= 0) chk("accept_cycle", 64'(n), 64'(exp_n));
    e.id  = 2'(exp_id);
    e.sse = exp_err ? 32'd0 : exp_sse(exp_id);
    e.err = exp_err;
    sb_q.push_back(e);
    step();
    req_valid = after_mask;
    @(negedge clk);
    chk("eng_start_hi", 64'(eng_start), 64'd1);
  endtask

  // From cycle 1, waits for rsp_valid and checks operand hold and latency.
  task automatic wait_rsp(input int exp_lat, input int id);
    int lat = 1;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      chk_wide("eng_a_hold", eng_a, {NBYTES{a_byte[id]}});
      chk_wide("eng_b_hold", eng_b, {NBYTES{b_byte[id]}});
      if (lat > 1) chk("eng_start_lo", 64'(eng_start), 64'd0);
      step();
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk_wide("eng_a_at_rsp", eng_a, {NBYTES{a_byte[id]}});
  endtask

  // Behavioural engine: done arrives eng_lat cycles after the start pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (eng_start === 1'b1) begin
        eng_cnt   = eng_lat;
        model_sse = engine_sse(eng_a, eng_b);
      end else if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0) model_done = eng_en;
      end
    end
  end

  // Scoreboard: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_sse", 64'(rsp_sse), 64'(mon_e.sse));
        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end else begin
        chk("rsp_unexpected", 64'(sb_q.size()), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = {NBYTES{a_byte[i]}};
      req_b[i*DATA_W +: DATA_W] = {NBYTES{b_byte[i]}};
    end

    // 1. Reset held with every requester valid.
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_eng_start", 64'(eng_start), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_sse", 64'(rsp_sse), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk_wide("rst_eng_a", eng_a, {DATA_W{1'b0}});
    end
    step();
    rst       = 1'b0;
    req_valid = 4'h0;

    // 2. Single request from requester 2 (expected SSE 1152).
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    accept(2, 4'b0000, 1'b0, 0);
    wait_rsp(12, 2);

    // 3. Round robin: all valid from pointer 0, then only 1 and 3.
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    accept(0, 4'hF, 1'b0, 0);   wait_rsp(12, 0);
    accept(1, 4'hF, 1'b0, 1);   wait_rsp(12, 1);
    accept(2, 4'hF, 1'b0, 1);   wait_rsp(12, 2);
    accept(3, 4'hF, 1'b0, 1);   wait_rsp(12, 3);
    accept(0, 4'b1010, 1'b0, 1); wait_rsp(12, 0);
    accept(1, 4'b1010, 1'b0, 1); wait_rsp(12, 1);
    accept(3, 4'b1010, 1'b0, 1); wait_rsp(12, 3);
    accept(1, 4'b0000, 1'b0, 1); wait_rsp(12, 1);

    // 4. Backpressure with another request pending.
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    accept(0, 4'b0001, 1'b0, 0);
    wait_rsp(12, 0);
    for (int c = 0; c < 20; c++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_id", 64'(rsp_id), 64'd0);
      chk("bp_rsp_sse", 64'(rsp_sse), 64'(exp_sse(0)));
      chk("bp_rsp_err", 64'(rsp_err), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_eng_start", 64'(eng_start), 64'd0);
      step();
      @(negedge clk);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    accept(0, 4'b0000, 1'b0, 1);
    wait_rsp(12, 0);

    // 5. Timeout, then a stray done in IDLE, then done coinciding with timeout.
    eng_en = 1'b0;
    step();
    req_valid = 4'b0010;
    @(negedge clk);
    accept(1, 4'b0000, 1'b1, 0);
    wait_rsp(2 + TIMEOUT, 1);
    eng_en = 1'b1;
    step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    @(negedge clk);
    chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("stray_eng_start", 64'(eng_start), 64'd0);
    step();
    req_valid = 4'b1100;
    @(negedge clk);
    accept(2, 4'b0000, 1'b0, 0);
    wait_rsp(12, 2);
    eng_lat = TIMEOUT;
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    accept(3, 4'b0000, 1'b0, 0);
    wait_rsp(2 + TIMEOUT, 3);
    eng_lat = SSE_ENG_LAT;

    // 6. Reset in WAIT discards the run and returns the pointer to 0.
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    accept(2, 4'b0000, 1'b0, 0);
    for (int c = 2; c <= 6; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb_q.pop_back());
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_eng_start", 64'(eng_start), 64'd0);
      step();
    end
    req_valid = 4'b1001;
    @(negedge clk);
    accept(0, 4'b0000, 1'b0, 0);
    wait_rsp(12, 0);

    step();
    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
